// File: rtl/match_scan_ctrl_pkg.sv
// Shared types and constants for the packet scan controller that drives the
// pattern-matching engine.
package match_scan_ctrl_pkg;

  localparam int CH_W          = 8;
  localparam int MAX_MATCH_LAT = 4;
  localparam int DRN_W         = $clog2(MAX_MATCH_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SCAN   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } scan_state_e;

  // States in which a scan is in flight and can still be cancelled.
  function automatic logic is_active(input scan_state_e s);
    return (s == S_CLEAR) || (s == S_SCAN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/match_scan_ctrl_if.sv
// Bundle of the scan controller's request, buffer-read, matcher and result
// signals; master is the controller side.
interface match_scan_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 8
);
  import match_scan_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W:0]   pkt_len;
  logic              abort;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [CH_W-1:0]   rd_data;
  logic [CH_W-1:0]   m_ch;
  logic              m_en;
  logic              m_clr;
  logic              m_final;
  logic              res_valid;
  logic              res_ready;
  logic              res_match;
  logic [ADDR_W-1:0] res_offset;
  logic [CNT_W-1:0]  res_count;

  modport master (
    input  start, pkt_len, abort, rd_data, m_final, res_ready,
    output busy, rd_addr, rd_en, m_ch, m_en, m_clr,
           res_valid, res_match, res_offset, res_count
  );

  modport slave (
    output start, pkt_len, abort, rd_data, m_final, res_ready,
    input  busy, rd_addr, rd_en, m_ch, m_en, m_clr,
           res_valid, res_match, res_offset, res_count
  );

endinterface

// File: rtl/match_scan_ctrl_offset_pipe.sv
// Delay line carrying {byte enable, byte offset} so each matcher final-state
// flag lines up with the offset of the byte that produced it.
module match_scan_ctrl_offset_pipe #(
  parameter int ADDR_W    = 11,
  parameter int MATCH_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] off_i,
  output logic              en_o,
  output logic [ADDR_W-1:0] off_o
);

  logic [MATCH_LAT-1:0] en_q;
  logic [ADDR_W-1:0]    off_q [MATCH_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '0;
      for (int i = 0; i < MATCH_LAT; i++) off_q[i] <= '0;
    end else if (clr_i) begin
      en_q <= '0;
      for (int i = 0; i < MATCH_LAT; i++) off_q[i] <= '0;
    end else begin
      en_q[0]  <= en_i;
      off_q[0] <= off_i;
      for (int i = 1; i < MATCH_LAT; i++) begin
        en_q[i]  <= en_q[i-1];
        off_q[i] <= off_q[i-1];
      end
    end
  end

  assign en_o  = en_q[MATCH_LAT-1];
  assign off_o = off_q[MATCH_LAT-1];

endmodule

// File: rtl/match_scan_ctrl.sv
// Sequences one stored packet through the pattern matcher and reports
// match flag, first-match offset and saturating match count.
module match_scan_ctrl
  import match_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 11,
  parameter int MATCH_LAT     = 1,
  parameter int CNT_W         = 8,
  parameter int STOP_ON_MATCH = 0
) (
  input  logic             clk,
  input  logic             reset,
  match_scan_ctrl_if.master bus
);

  localparam int              LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic              match;
    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  count;
  } res_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  scan_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              clr_pend_q, clr_pend_d;
  res_t              res_q, res_d;

  logic              in_scan, in_drain, m_clr, rd_en;
  logic              dly_en, hit, stop_now;
  logic [ADDR_W-1:0] dly_off;

  assign in_scan  = (state_q == S_SCAN);
  assign in_drain = (state_q == S_DRAIN);
  assign idx_nxt  = idx_q + LEN_W'(1);
  assign m_clr    = (state_q == S_CLEAR) || clr_pend_q;

  match_scan_ctrl_offset_pipe #(
    .ADDR_W   (ADDR_W),
    .MATCH_LAT(MATCH_LAT)
  ) u_offset_pipe (
    .clk  (clk),
    .reset(reset),
    .clr_i(m_clr),
    .en_i (in_scan),
    .off_i(idx_q[ADDR_W-1:0]),
    .en_o (dly_en),
    .off_o(dly_off)
  );

  // With stop-on-match, flags after the first one belong to bytes still in flight.
  assign hit      = bus.m_final && dly_en && (in_scan || in_drain)
                    && !((STOP_ON_MATCH != 0) && res_q.match);
  assign stop_now = (STOP_ON_MATCH != 0) && hit && in_scan;

  // Byte 0 is fetched in CLEAR; SCAN fetches byte idx+1 while byte idx is consumed.
  assign rd_en = (state_q == S_CLEAR) || (in_scan && (idx_nxt < len_q) && !stop_now);

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = (in_scan && rd_en) ? idx_nxt[ADDR_W-1:0] : '0;
  assign bus.m_en       = in_scan;
  assign bus.m_ch       = in_scan ? bus.rd_data : '0;
  assign bus.m_clr      = m_clr;
  assign bus.res_valid  = (state_q == S_RESULT);
  assign bus.res_match  = res_q.match;
  assign bus.res_offset = res_q.offset;
  assign bus.res_count  = res_q.count;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    drn_d      = drn_q;
    res_d      = res_q;
    clr_pend_d = 1'b0;

    if (hit) begin
      if (!res_q.match) begin
        res_d.match  = 1'b1;
        res_d.offset = dly_off;
      end
      res_d.count = sat_inc(res_q.count);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = clamp_len(bus.pkt_len);
          idx_d   = '0;
          drn_d   = '0;
          res_d   = '0;
          state_d = (bus.pkt_len == '0) ? S_RESULT : S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        idx_d = idx_nxt;
        if ((idx_nxt == len_q) || stop_now) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(MATCH_LAT - 1)) state_d = S_RESULT;
        else                                 drn_d   = drn_q + DRN_W'(1);
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && is_active(state_q)) begin
      state_d    = S_IDLE;
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      drn_q      <= '0;
      clr_pend_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      drn_q      <= drn_d;
      clr_pend_q <= clr_pend_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Bench for match_scan_ctrl: three instances (latency 1, latency 1 with
// stop-on-match, latency 3) share one packet buffer and a "pow" matcher model.
module tb_match_scan_ctrl;

  localparam int AW = 11;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW:0] pkt_len = '0;
  logic abort = 1'b0;
  logic res_ready = 1'b1;
  logic inj = 1'b0;
  logic [7:0] mem [2048];

  logic [2:0] vw, busy_w, men_w, rd_w, clr_w, match_w;
  logic [AW-1:0] off_w [3];
  logic [7:0] cnt_w [3];

  always #5 clk = ~clk;

  match_scan_ctrl_if #(.ADDR_W(AW), .CNT_W(8)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ML  = (g == 2) ? 3 : 1;
    localparam int SOM = (g == 1) ? 1 : 0;
    logic [1:0]    mst;
    logic [ML-1:0] fpipe;
    logic          hit;

    assign bus[g].start     = start;
    assign bus[g].pkt_len   = pkt_len;
    assign bus[g].abort     = abort;
    assign bus[g].res_ready = res_ready;
    assign bus[g].m_final   = fpipe[ML-1] | inj;

    assign vw[g]      = bus[g].res_valid;
    assign busy_w[g]  = bus[g].busy;
    assign men_w[g]   = bus[g].m_en;
    assign rd_w[g]    = bus[g].rd_en;
    assign clr_w[g]   = bus[g].m_clr;
    assign match_w[g] = bus[g].res_match;
    assign off_w[g]   = bus[g].res_offset;
    assign cnt_w[g]   = bus[g].res_count;

    always @(posedge clk) if (bus[g].rd_en) bus[g].rd_data <= mem[bus[g].rd_addr];

    // Matcher model for the string "pow" with ML cycles of flag latency.
    assign hit = bus[g].m_en && (mst == 2'd2) && (bus[g].m_ch == 8'h77);
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        mst   <= 2'd0;
        fpipe <= '0;
      end else begin
        if (bus[g].m_clr) mst <= 2'd0;
        else if (bus[g].m_en) begin
          if (bus[g].m_ch == 8'h70)                     mst <= 2'd1;
          else if (mst == 2'd1 && bus[g].m_ch == 8'h6f) mst <= 2'd2;
          else                                          mst <= 2'd0;
        end
        fpipe[0] <= hit;
        for (int i = 1; i < ML; i++) fpipe[i] <= fpipe[i-1];
      end
    end

    match_scan_ctrl #(
      .ADDR_W(AW), .MATCH_LAT(ML), .CNT_W(8), .STOP_ON_MATCH(SOM)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );
  end

  typedef struct {
    logic [63:0] s;
    int len; bit inj;
    bit m; int off; int cnt; int scnt;
    int c0; int c1; int c2;
  } vec_t;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int vcyc [3];
  int vm [3];
  int voff [3];
  int vcnt [3];
  int rdcnt0, mencnt0;
  logic men1 [64];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load8(input logic [63:0] s);
    for (int i = 0; i < 8; i++) mem[i] = s[63-8*i -: 8];
  endtask

  task automatic run_pkt(input int len, input int inj_at);
    int k;
    bit all;
    for (int g = 0; g < 3; g++) begin
      vcyc[g] = -1; vm[g] = 0; voff[g] = 0; vcnt[g] = 0;
    end
    rdcnt0 = 0; mencnt0 = 0;
    for (int i = 0; i < 64; i++) men1[i] = 1'b0;
    pkt_len = len[AW:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; all = 1'b0;
    while (!all && k < 4000) begin
      for (int g = 0; g < 3; g++) begin
        if (vw[g] && vcyc[g] < 0) begin
          vcyc[g] = k;
          vm[g]   = int'(match_w[g]);
          voff[g] = int'(off_w[g]);
          vcnt[g] = int'(cnt_w[g]);
        end
      end
      if (rd_w[0])  rdcnt0++;
      if (men_w[0]) mencnt0++;
      if (k < 64) men1[k] = men_w[1];
      all = (vcyc[0] >= 0) && (vcyc[1] >= 0) && (vcyc[2] >= 0);
      inj = (k == inj_at);
      @(negedge clk);
      k++;
    end
    inj = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    load8(v.s);
    run_pkt(v.len, v.inj ? 1 : -1);
    chk({tag, ".cyc0"}, vcyc[0], v.c0);
    chk({tag, ".cyc1"}, vcyc[1], v.c1);
    chk({tag, ".cyc2"}, vcyc[2], v.c2);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s.match%0d", tag, g), vm[g], v.m);
      chk($sformatf("%s.off%0d", tag, g), voff[g], v.off);
      chk($sformatf("%s.cnt%0d", tag, g), vcnt[g], (g == 1) ? v.scnt : v.cnt);
    end
    chk({tag, ".reads"}, rdcnt0, v.len);
    chk({tag, ".m_en_cycles"}, mencnt0, v.len);
    chk({tag, ".idle_after"}, busy_w, 0);
  endtask

  initial begin
    logic [AW-1:0] fo;
    logic [7:0] fc;
    bit seen;

    //          string      len inj m off cnt scnt c0 c1 c2
    vt[0] = '{"apowefgh", 8, 0, 1, 3, 1, 1, 11, 8, 13};
    vt[1] = '{"powpowxx", 6, 0, 1, 2, 2, 1,  9, 7, 11};
    vt[2] = '{"powpowpo", 0, 0, 0, 0, 0, 0,  1, 1,  1};
    vt[3] = '{"abcdefgh", 8, 1, 0, 0, 0, 0, 11, 11, 13};
    vt[4] = '{"powxxxxx", 3, 0, 1, 2, 1, 1,  6, 6,  8};
    vt[5] = '{"xpowpoww", 5, 0, 1, 3, 1, 1,  8, 8, 10};

    @(negedge clk);
    chk("rst.busy", busy_w, 0);
    chk("rst.rd_en", rd_w, 0);
    chk("rst.m_en", men_w, 0);
    chk("rst.m_clr", clr_w, 0);
    chk("rst.valid", vw, 0);
    chk("rst.match", match_w, 0);
    chk("rst.count", cnt_w[0], 0);
    chk("rst.offset", off_w[0], 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      check_vec(vt[i], $sformatf("v%0d", i));
      if (i == 1) begin
        chk("stop.m_en_flag_cycle", men1[5], 1);
        chk("stop.m_en_after_flag", men1[6], 0);
      end
    end

    // Oversized length clamps to the full buffer; 682 matches saturate the count.
    for (int i = 0; i < 2048; i++)
      mem[i] = (i % 3 == 0) ? 8'h70 : (i % 3 == 1) ? 8'h6f : 8'h77;
    run_pkt(4095, -1);
    chk("clamp.cyc0", vcyc[0], 2051);
    chk("clamp.cyc2", vcyc[2], 2053);
    chk("clamp.reads", rdcnt0, 2048);
    chk("clamp.cnt0", vcnt[0], 255);
    chk("clamp.cnt2", vcnt[2], 255);
    chk("clamp.off0", voff[0], 2);
    chk("clamp.cyc1", vcyc[1], 7);
    chk("clamp.cnt1", vcnt[1], 1);

    // Abort on the 4th SCAN cycle.
    load8("apowefgh");
    pkt_len = 12'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.in_scan", men_w, 3'b111);
    abort = 1'b1;
    @(negedge clk);
    chk("abort.busy", busy_w, 0);
    chk("abort.m_clr", clr_w, 3'b111);
    abort = 1'b0;
    @(negedge clk);
    chk("abort.m_clr_once", clr_w, 0);
    seen = 1'b0;
    repeat (15) begin
      if (vw != 3'b000) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort.no_result", seen, 0);
    check_vec(vt[0], "abort_rerun");

    // Result held while res_ready is low; start and abort ignored in RESULT.
    load8("apowefgh");
    res_ready = 1'b0;
    pkt_len = 12'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold.valid", vw, 3'b111);
    fo = off_w[0];
    fc = cnt_w[0];
    chk("hold.off", fo, 3);
    chk("hold.cnt", fc, 1);
    for (int h = 0; h < 5; h++) begin
      start = 1'b1;
      abort = (h == 2);
      @(negedge clk);
      chk($sformatf("hold%0d.valid", h), vw[0], 1);
      chk($sformatf("hold%0d.off", h), off_w[0], fo);
      chk($sformatf("hold%0d.cnt", h), cnt_w[0], fc);
    end
    abort = 1'b0;
    start = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("b2b.start_ignored", busy_w, 0);
    chk("b2b.valid_low", vw, 0);
    start = 1'b0;
    check_vec(vt[1], "after_hold");

    // Asynchronous reset between clock edges in the middle of SCAN.
    load8("apowefgh");
    pkt_len = 12'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.in_scan", men_w, 3'b111);
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", busy_w, 0);
    chk("arst.m_en", men_w, 0);
    chk("arst.rd_en", rd_w, 0);
    chk("arst.m_clr", clr_w, 0);
    chk("arst.valid", vw, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_vec(vt[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
